// File: rtl/disp_pattern_gen.sv
// Display timing and test-pattern generator.
// Produces VGA-style sync/enable timing from a pixel-clock counter pair and
// paints one of three test patterns (colour bars, character grid, custom
// coordinate ramp). The pattern mode only changes between frames.
module disp_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  mode_in,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic [1:0]  mode_applied,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_reg;

  // Counters widened to 32 bits so every comparison against the integer
  // timing parameters is done at one width with no truncation.
  logic [31:0] hx;
  logic [31:0] vy;

  logic        h_wrap;
  logic        frame_end;
  logic        visible;
  logic        hs_active;
  logic        vs_active;
  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb;
  logic [15:0] pix_rgb;

  assign hx        = 32'(h_cnt);
  assign vy        = 32'(v_cnt);
  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);
  assign visible   = (hx < H_ACTIVE) && (vy < V_ACTIVE);
  assign hs_active = (hx >= H_SYNC_START) && (hx < H_SYNC_END);
  assign vs_active = (vy >= V_SYNC_START) && (vy < V_SYNC_END);

  assign mode_applied = mode_reg;

  // Raster position: h_cnt runs every clock, v_cnt steps on each line wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Mode is latched only on the last pixel of a frame; 0 is treated as bars.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_reg <= 2'd1;
    end else if (frame_end) begin
      mode_reg <= (mode_in == 2'd0) ? 2'd1 : mode_in;
    end
  end

  // Bar index = min(x / BAR_W, 7) by counting bar boundaries already passed,
  // which needs only constant comparators instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hx >= 32'(k * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  // Colour-bar palette in RGB565, white down to black.
  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  // Pattern selection for the current pixel under the latched mode.
  always_comb begin
    pix_rgb = 16'h0000;
    case (mode_reg)
      2'd2:    pix_rgb = (hx[2:0] == 3'd0 || vy[3:0] == 4'd0) ? 16'hFFFF : 16'h0000;
      2'd3:    pix_rgb = {hx[7:3], vy[8:3], hx[7:3]};
      default: pix_rgb = bar_rgb;
    endcase
  end

  // All video outputs registered together so they share one clock of latency.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= 16'h0000;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~hs_active;
      vsync       <= ~vs_active;
      de          <= visible;
      rgb         <= visible ? pix_rgb : 16'h0000;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_disp_pattern_gen.sv
// Self-checking bench for disp_pattern_gen using reduced timing.
// A second instance with a taller active area holds custom mode so the
// pixel at (8,8) is visible.
module tb_disp_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CVA = 16;
  localparam int CVT = CVA + VF + VS + VB;
  localparam int CFRAME = HT * CVT;

  localparam logic [15:0] BAR_COLORS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [15:0] BAR_LINE [16] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0,
                                             16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                                             16'hF81F, 16'hF81F, 16'hF800, 16'hF800,
                                             16'h001F, 16'h001F, 16'h0000, 16'h0000};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  mode_in;
  logic        hsync, vsync, de, frame_start;
  logic [15:0] rgb;
  logic [1:0]  mode_applied;

  logic        rst_c_n;
  logic [1:0]  mode_c = 2'd3;
  logic        hsync_c, vsync_c, de_c, frame_start_c;
  logic [15:0] rgb_c;
  logic [1:0]  mode_applied_c;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int model_cnt = 0;
  int model_mode = 1;
  int cur_pos = 0;
  logic        exp_hs, exp_vs, exp_de, exp_fs;
  logic [15:0] exp_rgb;
  logic [1:0]  exp_mode;

  int c_edges = 0;

  int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_seen[$];
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  logic measure = 1'b1;

  logic [15:0] line_rgb [24];
  logic        line_de  [24];

  disp_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_in(mode_in),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .mode_applied(mode_applied), .frame_start(frame_start)
  );

  disp_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(CVA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(rst_c_n), .mode_in(mode_c),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .rgb(rgb_c),
    .mode_applied(mode_applied_c), .frame_start(frame_start_c)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (rst_c_n) c_edges <= c_edges + 1;
  end

  // Pattern value from the rules: bars by division, grid by modulo, custom by shifts.
  function automatic logic [15:0] ref_pixel(input int x, input int y, input int mode);
    int idx;
    case (mode)
      2: return ((x % 8 == 0) || (y % 16 == 0)) ? 16'hFFFF : 16'h0000;
      3: return 16'(((x / 8) % 32) * 2048 + ((y / 8) % 64) * 32 + ((x / 8) % 32));
      default: begin
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        return BAR_COLORS[idx];
      end
    endcase
  endfunction

  task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m);
    mode_in = m;
  endtask

  task automatic checkOutput();
    int cp, cx, cy, cmode;
    logic cvis;
    check1($sformatf("hsync@%0d", cur_pos), 16'(hsync), 16'(exp_hs));
    check1($sformatf("vsync@%0d", cur_pos), 16'(vsync), 16'(exp_vs));
    check1($sformatf("de@%0d", cur_pos), 16'(de), 16'(exp_de));
    check1($sformatf("rgb@%0d", cur_pos), rgb, exp_rgb);
    check1($sformatf("frame_start@%0d", cur_pos), 16'(frame_start), 16'(exp_fs));
    check1($sformatf("mode_applied@%0d", cur_pos), 16'(mode_applied), 16'(exp_mode));
    if (measure) begin
      if (prev_hs === 1'b1 && hsync === 1'b0) hs_fall.push_back(model_cnt);
      if (prev_hs === 1'b0 && hsync === 1'b1) hs_rise.push_back(model_cnt);
      if (prev_vs === 1'b1 && vsync === 1'b0) vs_fall.push_back(model_cnt);
      if (prev_vs === 1'b0 && vsync === 1'b1) vs_rise.push_back(model_cnt);
      if (frame_start === 1'b1) fs_seen.push_back(model_cnt);
    end
    prev_hs = hsync;
    prev_vs = vsync;
    if (c_edges > 0) begin
      cp    = (c_edges - 1) % CFRAME;
      cx    = cp % HT;
      cy    = cp / HT;
      cmode = (c_edges > CFRAME) ? 3 : 1;
      cvis  = (cx < HA) && (cy < CVA);
      check1($sformatf("c_rgb@%0d", cp), rgb_c, cvis ? ref_pixel(cx, cy, cmode) : 16'h0000);
      check1($sformatf("c_de@%0d", cp), 16'(de_c), 16'(cvis));
      check1($sformatf("c_vsync@%0d", cp), 16'(vsync_c), 16'(!(cy >= CVA + VF && cy < CVA + VF + VS)));
      check1($sformatf("c_mode@%0d", cp), 16'(mode_applied_c), (c_edges >= CFRAME) ? 16'd3 : 16'd1);
      if (cp == 8 * HT + 8 && c_edges > CFRAME) check1("custom_x8y8", rgb_c, 16'h0821);
    end
  endtask

  // One clock: predict the outputs for the current raster position, then compare.
  task automatic tick();
    int p, x, y;
    p = model_cnt % FRAME;
    x = p % HT;
    y = p / HT;
    exp_de  = (x < HA) && (y < VA);
    exp_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
    exp_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
    exp_fs  = (p == 0);
    exp_rgb = exp_de ? ref_pixel(x, y, model_mode) : 16'h0000;
    if (p == FRAME - 1) model_mode = (mode_in == 2'd0) ? 1 : int'(mode_in);
    exp_mode = 2'(model_mode);
    cur_pos = p;
    model_cnt++;
    @(posedge sys_clk);
    #1;
    checkOutput();
  endtask

  task automatic runTo(input int target);
    int guard;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (cur_pos != target && guard < FRAME + 2);
  endtask

  task automatic checkReset(input string tag);
    check1({tag, "_hsync"}, 16'(hsync), 16'd1);
    check1({tag, "_vsync"}, 16'(vsync), 16'd1);
    check1({tag, "_de"}, 16'(de), 16'd0);
    check1({tag, "_rgb"}, rgb, 16'h0000);
    check1({tag, "_frame_start"}, 16'(frame_start), 16'd0);
    check1({tag, "_mode"}, 16'(mode_applied), 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b1;
    rst_c_n   = 1'b1;
    applyStimulus(2'd1);
    #2;
    sys_rst_n = 1'b0;
    rst_c_n   = 1'b0;
    #1;
    checkReset("por");
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    rst_c_n   = 1'b1;
    model_cnt = 0;
    model_mode = 1;

    tick();
    check1("first_de", 16'(de), 16'd1);
    check1("first_fs", 16'(frame_start), 16'd1);
    check1("first_rgb", rgb, 16'hFFFF);
    line_rgb[0] = rgb;
    line_de[0]  = de;
    for (int i = 1; i < HT; i++) begin
      tick();
      line_rgb[i] = rgb;
      line_de[i]  = de;
    end
    for (int i = 0; i < HA; i++) check1($sformatf("bar_line_x%0d", i), line_rgb[i], BAR_LINE[i]);
    for (int i = HA; i < HT; i++) begin
      check1($sformatf("blank_de_x%0d", i), 16'(line_de[i]), 16'd0);
      check1($sformatf("blank_rgb_x%0d", i), line_rgb[i], 16'h0000);
    end

    runTo(FRAME - 1);
    runTo(FRAME - 1);
    tick();
    measure = 1'b0;
    check1("hsync_low_width", (hs_fall.size() > 0 && hs_rise.size() > 0) ? 16'(hs_rise[0] - hs_fall[0]) : 16'hFFFF, 16'd3);
    check1("line_period", (hs_fall.size() > 1) ? 16'(hs_fall[1] - hs_fall[0]) : 16'hFFFF, 16'(HT));
    check1("vsync_low_width", (vs_fall.size() > 0 && vs_rise.size() > 0) ? 16'(vs_rise[0] - vs_fall[0]) : 16'hFFFF, 16'(2 * HT));
    check1("frame_period_fs", (fs_seen.size() > 1) ? 16'(fs_seen[1] - fs_seen[0]) : 16'hFFFF, 16'(12 * HT));
    check1("frame_period_vs", (vs_fall.size() > 1) ? 16'(vs_fall[1] - vs_fall[0]) : 16'hFFFF, 16'(12 * HT));

    runTo(100);
    applyStimulus(2'd2);
    runTo(FRAME - 2);
    check1("mode_hold", 16'(mode_applied), 16'd1);
    tick();
    check1("mode_switch", 16'(mode_applied), 16'd2);
    tick();
    check1("grid_origin", rgb, 16'hFFFF);
    runTo(HT + 1);
    check1("grid_x1y1", rgb, 16'h0000);

    applyStimulus(2'd0);
    runTo(FRAME - 1);
    check1("invalid_mode", 16'(mode_applied), 16'd1);
    runTo(2);
    check1("invalid_bar_x2", rgb, 16'hFFE0);

    for (int n = 0; n < 4 * FRAME; n++) begin
      if ($urandom_range(0, 39) == 0) applyStimulus(2'($urandom_range(0, 3)));
      tick();
    end

    runTo(5 * HT + 10);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkReset("midframe");
    applyStimulus(2'd3);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    model_cnt = 0;
    model_mode = 1;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    tick();
    check1("post_reset_fs", 16'(frame_start), 16'd1);
    check1("post_reset_mode", 16'(mode_applied), 16'd1);
    check1("post_reset_rgb", rgb, 16'hFFFF);
    tick();
    check1("fs_one_clock", 16'(frame_start), 16'd0);
    runTo(FRAME - 1);
    check1("custom_applied", 16'(mode_applied), 16'd3);

    for (int n = 0; n < 2 * FRAME; n++) begin
      if ($urandom_range(0, 29) == 0) applyStimulus(2'($urandom_range(0, 3)));
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
